// File: rtl/multimode_ping_pong_counter.sv
// multimode_ping_pong_counter: parametrised bounce / wrap-up / wrap-down counter
// with programmable step, synchronous load and a one-cycle turn-around pulse.
module multimode_ping_pong_counter #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  output logic             direction,
  output logic [WIDTH-1:0] out,
  output logic             event_p,
  output logic             range_err
);
  typedef enum logic [1:0] {BOUNCE = 2'b00, WRAP_UP = 2'b01, WRAP_DN = 2'b10, HOLD = 2'b11} mode_e;
  mode_e            mode_m;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d, ev_q, ev_d;
  logic [WIDTH:0]   up_sum, dn_lim;
  logic             over, under, in_range, at_bound, nd, load_ok, active;
  assign mode_m    = mode_e'(mode);
  assign range_err = max <= min;
  // Extra carry bit keeps out+step and min+step exact, so bounds compare without overflow.
  assign up_sum    = {1'b0, out_q} + {1'b0, step};
  assign dn_lim    = {1'b0, min} + {1'b0, step};
  assign over      = up_sum > {1'b0, max};
  assign under     = {1'b0, out_q} < dn_lim;
  assign in_range  = out_q >= min && out_q <= max;
  assign at_bound  = (out_q == max && !dir_q) || (out_q == min && dir_q);
  // A flip at a bound cancels the automatic reversal: exactly one toggle at most.
  assign nd        = dir_q ^ (flip ^ at_bound);
  assign load_ok   = range_err || (load_val >= min && load_val <= max);
  assign active    = !range_err && enable && mode_m != HOLD;
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ev_d  = 1'b0;
    if (load) out_d = load_ok ? load_val : min;
    else if (active && !in_range) begin
      out_d = min;
      dir_d = 1'b0;
    end else if (active) begin
      case (mode_m)
        BOUNCE: begin
          dir_d = nd;
          ev_d  = nd ^ dir_q;
          out_d = nd ? (under ? min : out_q - step) : (over ? max : up_sum[WIDTH-1:0]);
        end
        WRAP_UP: begin
          dir_d = 1'b0;
          ev_d  = over;
          out_d = over ? min : up_sum[WIDTH-1:0];
        end
        WRAP_DN: begin
          dir_d = 1'b1;
          ev_d  = under;
          out_d = under ? max : out_q - step;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RST_VAL;
      dir_q <= 1'b0;
      ev_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      ev_q  <= ev_d;
    end
  end
  assign out       = out_q;
  assign direction = dir_q;
  assign event_p   = ev_q;
endmodule

// File: tb/tb_multimode_ping_pong_counter.sv
// tb_multimode_ping_pong_counter: directed vector table, async-reset sequence and
// randomized run, all checked against a signed-integer behavioural model.
module tb_multimode_ping_pong_counter;
  logic       clk = 0, rst_n = 0, enable = 0, flip = 0, load = 0;
  logic [7:0] load_val = 0, step = 0, max = 0, min = 0, out;
  logic [1:0] mode = 0;
  logic       direction, event_p, range_err;

  multimode_ping_pong_counter #(.WIDTH(8), .RST_VAL(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .load(load),
    .load_val(load_val), .step(step), .mode(mode), .max(max), .min(min),
    .direction(direction), .out(out), .event_p(event_p), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en, fl, ld;
    int lv, st, md, mn, mx;
    int eo, ed, ee, er;
  } vec_t;

  vec_t tab[$];
  int   total = 0, passed = 0;
  int   m_out = 0, m_dir = 0, m_ev = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic add(input bit en, fl, ld, input int lv, st, md, mn, mx, eo, ed, ee, er);
    vec_t v;
    v = '{en: en, fl: fl, ld: ld, lv: lv, st: st, md: md, mn: mn, mx: mx, eo: eo, ed: ed, ee: ee, er: er};
    tab.push_back(v);
  endtask

  // Spec rules evaluated on plain signed integers; clamping replaces any wrap-around.
  task automatic model_step(input vec_t v);
    int re, nd, t;
    re = (v.mx <= v.mn);
    m_ev = 0;
    if (v.ld) m_out = (re || (v.lv >= v.mn && v.lv <= v.mx)) ? v.lv : v.mn;
    else if (re || !v.en || v.md == 3) ;
    else if (m_out < v.mn || m_out > v.mx) begin
      m_out = v.mn;
      m_dir = 0;
    end else if (v.md == 0) begin
      nd = (m_dir + v.fl + (m_out == v.mx && m_dir == 0) + (m_out == v.mn && m_dir == 1)) % 2;
      t = nd ? m_out - v.st : m_out + v.st;
      m_out = t < v.mn ? v.mn : (t > v.mx ? v.mx : t);
      m_ev = (nd != m_dir);
      m_dir = nd;
    end else if (v.md == 1) begin
      m_dir = 0;
      if (m_out + v.st > v.mx) begin m_out = v.mn; m_ev = 1; end
      else m_out = m_out + v.st;
    end else begin
      m_dir = 1;
      if (m_out - v.st < v.mn) begin m_out = v.mx; m_ev = 1; end
      else m_out = m_out - v.st;
    end
  endtask

  task automatic cycle(input vec_t v, input bit use_tab);
    enable = v.en; flip = v.fl; load = v.ld; load_val = 8'(v.lv);
    step = 8'(v.st); mode = 2'(v.md); min = 8'(v.mn); max = 8'(v.mx);
    #1;
    check("range_err_model", range_err, v.mx <= v.mn);
    if (use_tab) check("range_err_tab", range_err, v.er);
    model_step(v);
    @(posedge clk); #1;
    check("out", out, m_out);
    check("direction", direction, m_dir);
    check("event_p", event_p, m_ev);
    if (use_tab) begin
      check("out_tab", out, v.eo);
      check("dir_tab", direction, v.ed);
      check("ev_tab", event_p, v.ee);
    end
  endtask

  initial begin
    vec_t v;
    //  en fl ld lv  st md mn mx   out dir ev err
    // bounce 2..6, step 1, starting from resync
    add(1, 0, 0, 0, 1, 0, 2, 6, 2, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 3, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 4, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 5, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 6, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 5, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 4, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 2, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 3, 0, 1, 0);
    // bounce 0..10 step 4 with clamping
    add(1, 0, 1, 0, 4, 0, 0, 10, 0, 0, 0, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 4, 0, 0, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 8, 0, 0, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 10, 0, 0, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 6, 1, 1, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 2, 1, 0, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 0, 1, 0, 0);
    add(1, 0, 0, 0, 4, 0, 0, 10, 4, 0, 1, 0);
    // wrap-up then wrap-down, 3..9 step 3
    add(1, 0, 1, 3, 3, 1, 3, 9, 3, 0, 0, 0);
    add(1, 0, 0, 0, 3, 1, 3, 9, 6, 0, 0, 0);
    add(1, 0, 0, 0, 3, 1, 3, 9, 9, 0, 0, 0);
    add(1, 0, 0, 0, 3, 1, 3, 9, 3, 0, 1, 0);
    add(1, 0, 0, 0, 3, 1, 3, 9, 6, 0, 0, 0);
    add(1, 0, 0, 0, 3, 2, 3, 9, 3, 1, 0, 0);
    add(1, 0, 0, 0, 3, 2, 3, 9, 9, 1, 1, 0);
    // flip at a bound cancels the automatic reversal
    add(1, 0, 1, 6, 1, 0, 2, 6, 6, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 2, 6, 6, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 2, 6, 6, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 5, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 4, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 2, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 3, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 2, 6, 4, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 2, 6, 3, 1, 1, 0);
    // load, range error, enable, step 0, hold, resync
    add(0, 0, 1, 20, 1, 0, 2, 6, 2, 1, 0, 0);
    add(0, 0, 1, 5, 1, 0, 2, 6, 5, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 7, 7, 5, 1, 0, 1);
    add(1, 1, 0, 0, 1, 0, 7, 7, 5, 1, 0, 1);
    add(1, 0, 1, 200, 1, 0, 7, 7, 200, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 255, 200, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 255, 200, 0, 1, 0);
    add(1, 0, 0, 0, 3, 3, 0, 255, 200, 0, 0, 0);
    add(1, 0, 0, 0, 1, 2, 0, 100, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 2, 0, 100, 100, 1, 1, 0);
    // full-range edges: no overflow or underflow past the type limits
    add(1, 0, 1, 250, 10, 1, 0, 255, 250, 1, 0, 0);
    add(1, 0, 0, 0, 10, 1, 0, 255, 0, 0, 1, 0);
    add(1, 0, 1, 5, 10, 2, 0, 255, 5, 0, 0, 0);
    add(1, 0, 0, 0, 10, 2, 0, 255, 255, 1, 1, 0);
    add(1, 0, 1, 250, 10, 0, 0, 255, 250, 1, 0, 0);
    add(1, 0, 0, 0, 10, 0, 0, 255, 240, 1, 0, 0);
    add(1, 1, 0, 0, 10, 0, 0, 255, 250, 0, 1, 0);
    add(1, 0, 0, 0, 10, 0, 0, 255, 255, 0, 0, 0);
    add(1, 0, 0, 0, 10, 0, 0, 255, 245, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_dir", direction, 0);
    check("reset_ev", event_p, 0);
    #2 rst_n = 1;

    foreach (tab[i]) cycle(tab[i], 1'b1);

    // async reset between edges, mid-count, with direction down
    v = '{en: 1, fl: 0, ld: 1, lv: 5, st: 1, md: 0, mn: 2, mx: 6, eo: 5, ed: 1, ee: 0, er: 0};
    cycle(v, 1'b1);
    #3 rst_n = 0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_dir", direction, 0);
    check("async_rst_ev", event_p, 0);
    m_out = 0; m_dir = 0; m_ev = 0;
    #1 rst_n = 1;
    v = '{en: 1, fl: 0, ld: 0, lv: 0, st: 1, md: 0, mn: 2, mx: 6, eo: 2, ed: 0, ee: 0, er: 0};
    cycle(v, 1'b1);

    v = '{en: 1, fl: 0, ld: 0, lv: 0, st: 1, md: 0, mn: 10, mx: 60, eo: 0, ed: 0, ee: 0, er: 0};
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) begin
        v.mn = $urandom_range(0, 200);
        v.mx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(v.mn, 255);
      end
      v.en = $urandom_range(0, 9) != 0;
      v.fl = $urandom_range(0, 9) == 0;
      v.ld = $urandom_range(0, 19) == 0;
      v.lv = $urandom_range(0, 255);
      v.st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      if (n % 8 == 0) v.md = $urandom_range(0, 3);
      cycle(v, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
